// File: rtl/mux_reg_n.sv
// N-input, WIDTH-bit selector with registered output, channel tag, illegal-select pulse and auto-scan pointer.
// Define MUX_REG_BYPASS_EN to add the combinational forwarding output o_comb.
module mux_reg_n #(
    parameter int              WIDTH     = 32,
    parameter int              NUM_IN    = 4,
    parameter int              SEL_W     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    ld,
    input  logic                    auto,
    input  logic                    ptr_clr,
    output logic [WIDTH-1:0]        o,
    output logic [SEL_W-1:0]        o_sel,
    output logic                    o_valid,
    output logic                    sel_err,
`ifdef MUX_REG_BYPASS_EN
    output logic [WIDTH-1:0]        o_comb,
`endif
    output logic [SEL_W-1:0]        ptr
);

    localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0] idx;
    logic             in_range;
    logic [WIDTH-1:0] sel_data;

    assign idx      = auto ? ptr : sel;
    assign in_range = ({1'b0, idx} < NUM_IN_L);

    // Constant-index compare per channel keeps every part-select in range; unmatched idx yields RESET_VAL.
    always_comb begin
        sel_data = RESET_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if ({1'b0, idx} == (SEL_W+1)'(k)) begin
                sel_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_REG_BYPASS_EN
    assign o_comb = sel_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= RESET_VAL;
            o_sel   <= '0;
            o_valid <= 1'b0;
            sel_err <= 1'b0;
            ptr     <= '0;
        end else begin
            sel_err <= 1'b0;
            if (ld) begin
                o       <= sel_data;
                o_sel   <= idx;
                sel_err <= !in_range;
                if (in_range) begin
                    o_valid <= 1'b1;
                end
            end
            // Clear beats advance; the load above still used the old pointer.
            if (ptr_clr) begin
                ptr <= '0;
            end else if (ld && auto) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + SEL_W'(1);
            end
        end
    end

endmodule

// File: doc/mux_reg_n.md
Name: mux_reg_n

Overview:
- Parametrised N-input, W-bit selector with a registered output. It generalises the team's fixed 2:1 32-bit combinational mux.
- Used on the multicycle datapath where an operand must be selected and then held across states, e.g. ALU source A/B and PC source. This removes separate holding registers after each mux.
- Adds a load enable, a registered channel tag, out-of-range select detection, and an auto-scan mode. Auto-scan uses an internal wrap-around pointer for sequential channel access, such as multi-word register dumps.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- RESET_VAL, 32'h0000_0000, value loaded into o on reset and on an illegal select.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, used when auto=0.
- ld  input  1  load strobe; captures the selected channel into o on the next rising edge.
- auto  input  1  1 = use the internal scan pointer instead of sel.
- ptr_clr  input  1  resets the scan pointer to 0.
- o  output  WIDTH  registered selected data.
- o_sel  output  SEL_W  channel index that produced the current o.
- o_valid  output  1  high once o holds data loaded since reset.
- sel_err  output  1  one-cycle pulse when a load used an index >= NUM_IN.
- ptr  output  SEL_W  current scan pointer.

Behaviour:
- Reset (rst=1 at a rising edge):
  - o=RESET_VAL, o_sel=0, o_valid=0, sel_err=0, ptr=0.
  - Reset wins over ld, auto and ptr_clr in the same cycle.
  - Reset asserted mid-scan discards the pointer position.
- Effective index: idx = auto ? ptr : sel.
- Load, on an edge with ld=1 and idx < NUM_IN:
  - o <= channel idx, o_sel <= idx, o_valid <= 1, sel_err <= 0.
- Illegal load, on an edge with ld=1 and idx >= NUM_IN:
  - o <= RESET_VAL, o_sel <= idx, o_valid unchanged, sel_err <= 1 for exactly one cycle.
  - Only reachable via sel, since ptr never exceeds NUM_IN-1.
- No load (ld=0): o, o_sel and o_valid hold their values; sel_err <= 0.
- Latency: o reflects in_bus as sampled at the ld edge. Data is visible one cycle after ld is asserted. Changes to in_bus after that edge do not affect o.
- Scan pointer, evaluated with priority in this order:
  - ptr_clr=1: ptr <= 0. If ld and auto are also 1 in the same cycle, the load uses the old ptr, and ptr becomes 0 rather than incrementing.
  - ld=1 and auto=1: ptr <= (ptr == NUM_IN-1) ? 0 : ptr+1. Wrap-around is required for non-power-of-two NUM_IN.
  - Otherwise ptr holds. Loads with auto=0 do not move ptr.
- Back-to-back ld every cycle is legal: one capture per edge, full throughput.
- Mode switch: auto may change on any cycle and takes effect for that cycle's idx; no pipeline bubble.
- Internal state: the pointer is a 2-branch counter; the output path is a plain register bank. No other FSM.

Optional Feature:
- Macro: MUX_REG_BYPASS_EN.
- When defined:
  - Adds output port o_comb (WIDTH), the combinational selected channel for the current idx. It equals RESET_VAL when idx >= NUM_IN.
  - Gives zero-latency forwarding to consumers that sample in the same state.
  - o_comb is independent of ld and of the registered state.
- When undefined: the port is absent and no combinational path exists from in_bus to any output.

Test Plan:
- Reset: assert rst 2 cycles with ld=1 -> o=0, o_valid=0, o_sel=0, ptr=0, sel_err=0.
- Manual load and hold: in_bus ch2=32'hDEAD_BEEF, sel=2, ld 1 cycle, then change ch2 to 32'h1234_5678 with ld=0 -> o=DEAD_BEEF, o_sel=2, o_valid=1, held unchanged for 5 cycles.
- Auto wrap with NUM_IN=3, SEL_W=2, channels 11/22/33, auto=1, ld for 4 consecutive cycles -> o sequence 11, 22, 33, 11; ptr sequence 1, 2, 0, 1.
- Illegal select with NUM_IN=3, sel=3, ld=1 -> next cycle o=RESET_VAL, o_sel=3, sel_err=1 for one cycle, o_valid unchanged.
- Clear collision: ptr=2, auto=1, ld=1, ptr_clr=1 -> o=ch2, ptr=0 on the next cycle; reset mid-scan at ptr=1 -> ptr=0.
- With MUX_REG_BYPASS_EN: sel=1, ch1=32'hA5A5_A5A5, ld=0 -> o_comb=A5A5_A5A5 in the same cycle, o unchanged; without the macro, elaboration shows no o_comb port.
